// File: rtl/microsequencer_pkg.sv
// -----------------------------------------------------------------------------
// useq_pkg
// Shared definitions for the microsequencer:
//   - STATE_W / ILLEGAL_STATE : microstore address width and the trap state
//   - S_* codes               : next-address source select
//   - N_* codes               : condition select
//   - OPC_* / FN_*            : recognised opcode and funct values
//   - ST_*                    : first microstate of each recognised instruction
// -----------------------------------------------------------------------------
package useq_pkg;

   localparam int unsigned STATE_W = 7;

   typedef logic [STATE_W-1:0] ustate_t;

   localparam ustate_t ILLEGAL_STATE = 7'd127;
   localparam ustate_t ST_FETCH      = 7'd0;

   // Next-address source select (S field)
   localparam logic [1:0] S_ENC  = 2'b00;
   localparam logic [1:0] S_INCR = 2'b01;
   localparam logic [1:0] S_CR   = 2'b10;
   localparam logic [1:0] S_COND = 2'b11;

   // Condition select (N field); 110 and 111 read as constant 0
   localparam logic [2:0] N_ZERO = 3'b000;
   localparam logic [2:0] N_ONE  = 3'b001;
   localparam logic [2:0] N_MOC  = 3'b010;
   localparam logic [2:0] N_Z    = 3'b011;
   localparam logic [2:0] N_NF   = 3'b100;
   localparam logic [2:0] N_BR   = 3'b101;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // First microstate of each instruction's execute routine
   localparam ustate_t ST_ADD  = 7'd10;
   localparam ustate_t ST_SUB  = 7'd12;
   localparam ustate_t ST_AND  = 7'd14;
   localparam ustate_t ST_OR   = 7'd16;
   localparam ustate_t ST_SLT  = 7'd18;
   localparam ustate_t ST_LW   = 7'd20;
   localparam ustate_t ST_JR   = 7'd22;
   localparam ustate_t ST_SW   = 7'd24;
   localparam ustate_t ST_BEQ  = 7'd28;
   localparam ustate_t ST_BNE  = 7'd30;
   localparam ustate_t ST_ADDI = 7'd32;
   localparam ustate_t ST_J    = 7'd34;

endpackage

// File: rtl/microsequencer_if.sv
// -----------------------------------------------------------------------------
// useq_if
// Bundles the microsequencer's sequencing fields, instruction fields, datapath
// status and outputs.
//   master : drives S, N, CR, Inv, IncRld, opcode, funct, MOC, Z, Nf, br_cond;
//            observes state, wd_fault
//   slave  : the sequencer side (inverse directions)
// -----------------------------------------------------------------------------
interface useq_if;
   import useq_pkg::*;

   logic [1:0]         S;
   logic [2:0]         N;
   logic [STATE_W-1:0] CR;
   logic               Inv;
   logic               IncRld;
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               MOC;
   logic               Z;
   logic               Nf;
   logic               br_cond;
   logic [STATE_W-1:0] state;
   logic               wd_fault;

   modport master (
      output S, N, CR, Inv, IncRld, opcode, funct, MOC, Z, Nf, br_cond,
      input  state, wd_fault
   );

   modport slave (
      input  S, N, CR, Inv, IncRld, opcode, funct, MOC, Z, Nf, br_cond,
      output state, wd_fault
   );

endinterface

// File: rtl/microsequencer_instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Purely combinational opcode/funct -> first microstate map.
//   opcode      in  6  IR[31:26]
//   funct       in  6  IR[5:0], only decoded for R-type (opcode == 0)
//   first_state out 7  entry microstate, ILLEGAL_STATE when unrecognised
// -----------------------------------------------------------------------------
module instr_encoder
   import useq_pkg::*;
(
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   output logic [STATE_W-1:0] first_state
);

   always_comb begin
      first_state = ILLEGAL_STATE;
      unique case (opcode)
         OPC_RTYPE: begin
            unique case (funct)
               FN_ADD:  first_state = ST_ADD;
               FN_SUB:  first_state = ST_SUB;
               FN_AND:  first_state = ST_AND;
               FN_OR:   first_state = ST_OR;
               FN_SLT:  first_state = ST_SLT;
               FN_JR:   first_state = ST_JR;
               default: first_state = ILLEGAL_STATE;
            endcase
         end
         OPC_J:    first_state = ST_J;
         OPC_BEQ:  first_state = ST_BEQ;
         OPC_BNE:  first_state = ST_BNE;
         OPC_ADDI: first_state = ST_ADDI;
         OPC_LW:   first_state = ST_LW;
         OPC_SW:   first_state = ST_SW;
         default:  first_state = ILLEGAL_STATE;
      endcase
   end

endmodule

// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
// Next-state sequencer of the microprogrammed control unit. Selects a
// condition, picks the next microstore address and registers it as state.
// Also holds the incrementer register used for sequential stepping and
// memory-wait loops.
//   clk    in  1  system clock, rising edge
//   reset  in  1  synchronous, active-high
//   bus    useq_if.slave  sequencing fields, instruction fields, status in;
//                         state (registered) and wd_fault out
// Optional feature: define USEQ_WATCHDOG_EN to add a stall watchdog that
// traps into ILLEGAL_STATE after WD_LIMIT cycles without an address change
// and raises a sticky wd_fault. Without it wd_fault is tied low.
// -----------------------------------------------------------------------------
module microsequencer #(
   parameter int unsigned              STATE_W       = 7,
   parameter logic [STATE_W-1:0]       ILLEGAL_STATE = 7'd127,
   parameter int unsigned              WD_LIMIT      = 255
) (
   input  logic  clk,
   input  logic  reset,
   useq_if.slave bus
);
   import useq_pkg::*;

   // Counter is 8 bits wide, so the threshold must fit in 1..255
   if (WD_LIMIT < 1 || WD_LIMIT > 255) begin : g_wd_limit_range
      $error("WD_LIMIT must be in 1..255");
   end

   logic [STATE_W-1:0] state_d, state_q;
   logic [STATE_W-1:0] incr_reg_d, incr_reg_q;
   logic [STATE_W-1:0] enc_state;
   logic [STATE_W-1:0] next_addr;
   logic               cond_sel;
   logic               cond;

   instr_encoder u_instr_encoder (
      .opcode      (bus.opcode),
      .funct       (bus.funct),
      .first_state (enc_state)
   );

   // Condition mux and next-address mux
   always_comb begin
      cond_sel = 1'b0;
      unique case (bus.N)
         N_ZERO:  cond_sel = 1'b0;
         N_ONE:   cond_sel = 1'b1;
         N_MOC:   cond_sel = bus.MOC;
         N_Z:     cond_sel = bus.Z;
         N_NF:    cond_sel = bus.Nf;
         N_BR:    cond_sel = bus.br_cond;
         default: cond_sel = 1'b0;
      endcase
      cond = cond_sel ^ bus.Inv;

      next_addr = enc_state;
      unique case (bus.S)
         S_ENC:   next_addr = enc_state;
         S_INCR:  next_addr = incr_reg_q;
         S_CR:    next_addr = bus.CR;
         S_COND:  next_addr = cond ? bus.CR : incr_reg_q;
         default: next_addr = enc_state;
      endcase
   end

`ifdef USEQ_WATCHDOG_EN
   localparam logic [7:0] WD_LIMIT_C = 8'(WD_LIMIT);

   logic [7:0] wd_cnt_d, wd_cnt_q;
   logic       wd_fault_d, wd_fault_q;
`endif

   always_comb begin
      state_d    = next_addr;
      // Natural 7-bit wrap: 127 + 1 -> 0
      incr_reg_d = bus.IncRld ? next_addr + 1'b1 : incr_reg_q;
`ifdef USEQ_WATCHDOG_EN
      // Count cycles where the address would not move; saturate at 255
      wd_cnt_d = 8'd0;
      if (next_addr == state_q) begin
         wd_cnt_d = (wd_cnt_q == 8'hFF) ? wd_cnt_q : wd_cnt_q + 8'd1;
      end
      // Trip on the edge the count reaches the limit; once tripped the
      // sequencer stays parked in the trap state until reset
      wd_fault_d = wd_fault_q | (wd_cnt_d == WD_LIMIT_C);
      if (wd_fault_d) begin
         state_d = ILLEGAL_STATE;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= '0;
         incr_reg_q <= STATE_W'(1);
      end else begin
         state_q    <= state_d;
         incr_reg_q <= incr_reg_d;
      end
   end

`ifdef USEQ_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt_q   <= 8'd0;
         wd_fault_q <= 1'b0;
      end else begin
         wd_cnt_q   <= wd_cnt_d;
         wd_fault_q <= wd_fault_d;
      end
   end

   assign bus.wd_fault = wd_fault_q;
`else
   assign bus.wd_fault = 1'b0;
`endif

   assign bus.state = state_q;

endmodule

// File: tb/tb_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_microsequencer
// Directed, table-driven bench for microsequencer. Each table record holds
// one cycle of inputs and the state expected after the following rising edge;
// multi-cycle corners (reset during a memory wait, watchdog stall) are
// written out as explicit sequences.
// -----------------------------------------------------------------------------
module tb_microsequencer;
   import useq_pkg::*;

   typedef struct {
      logic       rst;
      logic [1:0] s;
      logic [2:0] n;
      logic [6:0] cr;
      logic       inv;
      logic       inc;
      logic [5:0] opc;
      logic [5:0] fn;
      logic       moc;
      logic       z;
      logic       nf;
      logic       bc;
      logic [6:0] exp_state;
   } vec_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

   useq_if u_if ();

   microsequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic [1:0] s,
                               input logic [2:0] n, input logic [6:0] cr,
                               input logic inv, input logic inc,
                               input logic [5:0] opc, input logic [5:0] fn,
                               input logic moc, input logic z, input logic nf,
                               input logic bc, input logic [6:0] exp_state);
      vec_t v;
      v.rst = rst; v.s = s; v.n = n; v.cr = cr; v.inv = inv; v.inc = inc;
      v.opc = opc; v.fn = fn; v.moc = moc; v.z = z; v.nf = nf; v.bc = bc;
      v.exp_state = exp_state;
      return v;
   endfunction

   // Drive one cycle of inputs away from the active edge, then sample
   // just after the edge that consumes them.
   task automatic apply(input vec_t v);
      @(negedge clk);
      reset        = v.rst;
      u_if.S       = v.s;
      u_if.N       = v.n;
      u_if.CR      = v.cr;
      u_if.Inv     = v.inv;
      u_if.IncRld  = v.inc;
      u_if.opcode  = v.opc;
      u_if.funct   = v.fn;
      u_if.MOC     = v.moc;
      u_if.Z       = v.z;
      u_if.Nf      = v.nf;
      u_if.br_cond = v.bc;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   vec_t tbl[$];
   vec_t hold;
   logic exp_wd;
   int   exp_st;

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b1;
      u_if.S = 2'b00; u_if.N = 3'b000; u_if.CR = 7'd0; u_if.Inv = 1'b0;
      u_if.IncRld = 1'b0; u_if.opcode = 6'h00; u_if.funct = 6'h00;
      u_if.MOC = 1'b0; u_if.Z = 1'b0; u_if.Nf = 1'b0; u_if.br_cond = 1'b0;

      //            rst s      n       cr   inv inc opc        fn      moc z nf bc  exp
      // reset with arbitrary inputs, two cycles
      tbl.push_back(mk(1, 2'b10, 3'b000, 40, 0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2'b11, 3'b101, 77, 1, 1, OPC_LW,    6'h00,  1, 1, 1, 1, 0));
      // increment chain from reset (incr_reg starts at 1)
      tbl.push_back(mk(0, 2'b01, 3'b000, 0,  0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2'b01, 3'b000, 0,  0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 2));
      tbl.push_back(mk(0, 2'b01, 3'b000, 0,  0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 3));
      // jump to 5, incr_reg <- 6
      tbl.push_back(mk(0, 2'b10, 3'b000, 5,  0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 5));
      // memory wait on MOC: hold 4 cycles, then advance to incr_reg = 6
      tbl.push_back(mk(0, 2'b11, 3'b010, 5,  1, 0, 6'h00,     6'h00,  0, 0, 0, 0, 5));
      tbl.push_back(mk(0, 2'b11, 3'b010, 5,  1, 0, 6'h00,     6'h00,  0, 0, 0, 0, 5));
      tbl.push_back(mk(0, 2'b11, 3'b010, 5,  1, 0, 6'h00,     6'h00,  0, 0, 0, 0, 5));
      tbl.push_back(mk(0, 2'b11, 3'b010, 5,  1, 0, 6'h00,     6'h00,  0, 0, 0, 0, 5));
      tbl.push_back(mk(0, 2'b11, 3'b010, 5,  1, 0, 6'h00,     6'h00,  1, 0, 0, 0, 6));
      // encoder dispatch
      tbl.push_back(mk(0, 2'b00, 3'b000, 0,  0, 0, OPC_LW,    6'h00,  0, 0, 0, 0, ST_LW));
      tbl.push_back(mk(0, 2'b00, 3'b000, 0,  0, 0, OPC_RTYPE, FN_SUB, 0, 0, 0, 0, ST_SUB));
      tbl.push_back(mk(0, 2'b00, 3'b000, 0,  0, 0, OPC_BEQ,   6'h00,  0, 0, 0, 0, ST_BEQ));
      tbl.push_back(mk(0, 2'b00, 3'b000, 0,  0, 0, OPC_RTYPE, 6'h3F,  0, 0, 0, 0, 127));
      // unmapped opcode -> 127 with IncRld: incr_reg wraps to 0
      tbl.push_back(mk(0, 2'b00, 3'b000, 0,  0, 1, 6'h3F,     6'h00,  0, 0, 0, 0, 127));
      tbl.push_back(mk(0, 2'b01, 3'b000, 0,  0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b01, 3'b000, 0,  0, 0, 6'h00,     6'h00,  0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2'b01, 3'b000, 0,  0, 0, 6'h00,     6'h00,  0, 0, 0, 0, 1));
      // conditional branches on each condition source
      tbl.push_back(mk(0, 2'b11, 3'b011, 50, 0, 1, 6'h00,     6'h00,  0, 1, 0, 0, 50));
      tbl.push_back(mk(0, 2'b11, 3'b011, 50, 0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 51));
      tbl.push_back(mk(0, 2'b11, 3'b100, 70, 0, 1, 6'h00,     6'h00,  0, 0, 1, 0, 70));
      tbl.push_back(mk(0, 2'b11, 3'b101, 90, 1, 1, 6'h00,     6'h00,  0, 0, 0, 0, 90));
      tbl.push_back(mk(0, 2'b11, 3'b001, 10, 0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 10));
      tbl.push_back(mk(0, 2'b11, 3'b000, 30, 0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 11));
      tbl.push_back(mk(0, 2'b11, 3'b110, 30, 0, 1, 6'h00,     6'h00,  1, 1, 1, 1, 12));
      tbl.push_back(mk(0, 2'b11, 3'b111, 30, 0, 1, 6'h00,     6'h00,  1, 1, 1, 1, 13));
      tbl.push_back(mk(0, 2'b11, 3'b010, 100,0, 1, 6'h00,     6'h00,  1, 0, 0, 0, 100));
      // reset beats a jump to 40; incr_reg back to 1
      tbl.push_back(mk(1, 2'b10, 3'b000, 40, 0, 1, 6'h00,     6'h00,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b01, 3'b000, 0,  0, 0, 6'h00,     6'h00,  0, 0, 0, 0, 1));

      foreach (tbl[i]) begin
         apply(tbl[i]);
         chk($sformatf("vec%0d_state", i), int'(u_if.state), int'(tbl[i].exp_state));
         chk($sformatf("vec%0d_wd_fault", i), int'(u_if.wd_fault), 0);
      end

      // Reset in the middle of a memory wait
      apply(mk(0, 2'b10, 3'b000, 5, 0, 1, 6'h00, 6'h00, 0, 0, 0, 0, 5));
      chk("midwait_enter", int'(u_if.state), 5);
      apply(mk(0, 2'b11, 3'b010, 5, 1, 0, 6'h00, 6'h00, 0, 0, 0, 0, 5));
      apply(mk(0, 2'b11, 3'b010, 5, 1, 0, 6'h00, 6'h00, 0, 0, 0, 0, 5));
      chk("midwait_hold", int'(u_if.state), 5);
      apply(mk(1, 2'b11, 3'b010, 5, 1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 0));
      chk("midwait_reset", int'(u_if.state), 0);
      apply(mk(0, 2'b01, 3'b000, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 1));
      chk("midwait_incr_after_reset", int'(u_if.state), 1);

      // Stall: unconditional self-loop at state 5
      apply(mk(0, 2'b10, 3'b000, 5, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 5));
      chk("stall_enter", int'(u_if.state), 5);
      hold = mk(0, 2'b11, 3'b000, 5, 1, 0, 6'h00, 6'h00, 0, 0, 0, 0, 5);
      for (int c = 0; c < 254; c++) apply(hold);
      chk("stall_254_state", int'(u_if.state), 5);
      chk("stall_254_wd_fault", int'(u_if.wd_fault), 0);
`ifdef USEQ_WATCHDOG_EN
      exp_st = 127;
      exp_wd = 1'b1;
`else
      exp_st = 5;
      exp_wd = 1'b0;
`endif
      apply(hold);
      chk("stall_255_state", int'(u_if.state), exp_st);
      chk("stall_255_wd_fault", int'(u_if.wd_fault), int'(exp_wd));
      for (int c = 0; c < 3; c++) begin
         apply(hold);
         chk($sformatf("stall_persist%0d_state", c), int'(u_if.state), exp_st);
         chk($sformatf("stall_persist%0d_wd_fault", c), int'(u_if.wd_fault), int'(exp_wd));
      end
      // Jump away: still trapped with the watchdog, free without it
      apply(mk(0, 2'b10, 3'b000, 40, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 40));
`ifdef USEQ_WATCHDOG_EN
      chk("stall_trap_sticky", int'(u_if.state), 127);
`else
      chk("stall_trap_sticky", int'(u_if.state), 40);
`endif
      chk("stall_trap_wd_fault", int'(u_if.wd_fault), int'(exp_wd));
      apply(mk(1, 2'b10, 3'b000, 40, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 0));
      chk("stall_reset_state", int'(u_if.state), 0);
      chk("stall_reset_wd_fault", int'(u_if.wd_fault), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
